riscv_i32_debug_master: RTL and testbench

- Initiator end of the RISC-V pipeline-debug bus.
- Accepts single debug commands from a host-side command port and issues each as a one-cycle debug_mst transaction to the addressed hart's pipeline debug target.
- Captures the target's debug_tgt response and returns it with status and error flags.
- While idle, broadcasts an attention scan and reports whether any hart requests attention.

---
 rtl/riscv_i32_debug_pkg.sv | 55 +++++
 rtl/riscv_i32_debug_master.sv | 160 ++++++++++++++++
 tb/tb_riscv_i32_debug_master.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_i32_debug_pkg.sv
// Shared types and constants for the RISC-V pipeline-debug bus.
// The master and every hart's pipeline debug target import this package.
package riscv_i32_debug_pkg;

    localparam logic [3:0] OP_CONTROL    = 4'd0;
    localparam logic [3:0] OP_WRITE_DATA = 4'd1;

    // Bit positions inside cmd_arg for OP_CONTROL
    localparam int unsigned HALT_REQ   = 0;
    localparam int unsigned RESUME_REQ = 1;

    // Bit positions inside rsp_status
    localparam int unsigned STATUS_RESP     = 0;
    localparam int unsigned STATUS_HALTED   = 1;
    localparam int unsigned STATUS_RESUMED  = 2;
    localparam int unsigned STATUS_HIT_BP   = 3;

    // Bit positions inside rsp_error
    localparam int unsigned ERR_TIMEOUT      = 0;
    localparam int unsigned ERR_SEL_MISMATCH = 1;

    localparam logic [5:0] MASK_ALL = 6'h3f;

    typedef struct packed {
        logic        valid;
        logic [5:0]  select;
        logic [5:0]  mask;
        logic [3:0]  op;
        logic [15:0] arg;
        logic [31:0] data;
    } debug_mst_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  selected;
        logic        halted;
        logic        resumed;
        logic        hit_breakpoint;
        logic        op_was_none;
        logic        resp;
        logic [31:0] data;
        logic        attention;
    } debug_tgt_t;

    function automatic logic [3:0] pack_status(input debug_tgt_t tgt);
        logic [3:0] s;
        s = '0;
        s[STATUS_RESP]    = tgt.resp;
        s[STATUS_HALTED]  = tgt.halted;
        s[STATUS_RESUMED] = tgt.resumed;
        s[STATUS_HIT_BP]  = tgt.hit_breakpoint;
        return s;
    endfunction

endpackage

// File: rtl/riscv_i32_debug_master.sv
// Initiator of the pipeline-debug bus: issues one host command at a time to a hart
// and returns the captured response; scans for hart attention while idle.
module riscv_i32_debug_master
    import riscv_i32_debug_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_select,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_arg,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_status,
    output logic [1:0]  rsp_error,
    output logic        attention,
    output debug_mst_t  debug_mst,
    input  debug_tgt_t  debug_tgt
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResult} state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [5:0]  sel_q, sel_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] arg_q, arg_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [3:0]  rsp_status_q, rsp_status_d;
    logic [1:0]  rsp_error_q, rsp_error_d;
    logic        attention_q, attention_d;
    logic        scan_d1_q;
    debug_mst_t  debug_mst_q, debug_mst_d;
    logic        scanning;
    logic        unused_op_was_none;

    assign unused_op_was_none = debug_tgt.op_was_none;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        op_d         = op_q;
        arg_d        = arg_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        rsp_error_d  = rsp_error_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    sel_d   = cmd_select;
                    op_d    = cmd_op;
                    arg_d   = cmd_arg;
                    data_d  = cmd_data;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (debug_tgt.valid) begin
                    rsp_data_d   = debug_tgt.data;
                    rsp_status_d = pack_status(debug_tgt);
                    rsp_error_d  = '0;
                    rsp_error_d[ERR_SEL_MISMATCH] = (debug_tgt.selected != sel_q);
                    state_d      = StResult;
                end else if (cnt_q == TimeoutLast) begin
                    rsp_data_d   = '0;
                    rsp_status_d = '0;
                    rsp_error_d  = 2'b01;
                    state_d      = StResult;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResult: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Bus drive follows the next state so it lines up with the registered FSM.
        // Idle/Result drive all-zero: mask=0 makes every target answer the attention scan.
        debug_mst_d = '0;
        if (state_d == StIssue) begin
            debug_mst_d.valid  = 1'b1;
            debug_mst_d.select = sel_d;
            debug_mst_d.mask   = MASK_ALL;
            debug_mst_d.op     = op_d;
            debug_mst_d.arg    = arg_d;
            debug_mst_d.data   = data_d;
        end else if (state_d == StWait) begin
            debug_mst_d       = debug_mst_q;
            debug_mst_d.valid = 1'b0;
        end
    end

    assign scanning = (state_q == StIdle) || (state_q == StResult);

    // Targets answer one cycle late, so only trust attention after two scan cycles in a row.
    always_comb begin
        attention_d = attention_q;
        if (scan_d1_q && scanning) begin
            attention_d = debug_tgt.attention;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            op_q         <= '0;
            arg_q        <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            rsp_error_q  <= '0;
            attention_q  <= 1'b0;
            scan_d1_q    <= 1'b0;
            debug_mst_q  <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            op_q         <= op_d;
            arg_q        <= arg_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            rsp_error_q  <= rsp_error_d;
            attention_q  <= attention_d;
            scan_d1_q    <= scanning;
            debug_mst_q  <= debug_mst_d;
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign rsp_valid  = (state_q == StResult);
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign rsp_error  = rsp_error_q;
    assign attention  = attention_q;
    assign debug_mst  = debug_mst_q;

endmodule

// File: tb/tb_riscv_i32_debug_master.sv
// Directed bench for riscv_i32_debug_master with a single behavioural pipeline debug
// target at hart select 5 that echoes command data and tracks halt/resume.
module tb_riscv_i32_debug_master;
    import riscv_i32_debug_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_select;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_status;
    logic [1:0]  rsp_error;
    logic        attention;
    debug_mst_t  mst;
    debug_tgt_t  tgt;

    int total = 0;
    int bad   = 0;
    int vcount = 0;
    int edges;
    int base;

    logic [5:0] rv_select;
    logic       tb_attn;
    logic       tb_any;
    logic       halted_q;
    logic       resumed_q;
    logic       match;
    logic       hit;

    riscv_i32_debug_master #(.TIMEOUT(15)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_select (cmd_select),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status),
        .rsp_error  (rsp_error),
        .attention  (attention),
        .debug_mst  (mst),
        .debug_tgt  (tgt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural target: registered, answers one cycle after it sees its request.
    assign match = (((mst.select ^ rv_select) & mst.mask) == 6'd0);
    assign hit   = mst.valid && (match || tb_any);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tgt       <= '0;
            halted_q  <= 1'b0;
            resumed_q <= 1'b0;
        end else begin
            tgt.valid          <= hit;
            tgt.selected       <= rv_select;
            tgt.data           <= hit ? mst.data : 32'd0;
            tgt.resp           <= hit;
            tgt.halted         <= halted_q;
            tgt.resumed        <= resumed_q;
            tgt.hit_breakpoint <= 1'b0;
            tgt.op_was_none    <= 1'b0;
            tgt.attention      <= match && tb_attn;
            if (hit && mst.op == OP_CONTROL) begin
                if (mst.arg[HALT_REQ]) begin
                    halted_q  <= 1'b1;
                    resumed_q <= 1'b0;
                end
                if (mst.arg[RESUME_REQ]) begin
                    halted_q  <= 1'b0;
                    resumed_q <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (mst.valid) vcount <= vcount + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered #1 after an edge with the FSM idle. Returns edges from the accept edge
    // (exclusive) until rsp_valid is seen, bounded.
    task automatic run_cmd(input logic [5:0] sel, input logic [3:0] op, input logic [15:0] arg,
                           input logic [31:0] data, output int n);
        cmd_valid  = 1'b1;
        cmd_select = sel;
        cmd_op     = op;
        cmd_arg    = arg;
        cmd_data   = data;
        check("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("issue_valid", mst.valid, 1);
        check("issue_mask", mst.mask, 6'h3f);
        check("issue_select", mst.select, sel);
        check("issue_data", mst.data, data);
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
            if (!rsp_valid) check("wait_no_valid", mst.valid, 0);
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("ack_rsp_valid_low", rsp_valid, 0);
        check("ack_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_select = '0;
        cmd_op     = '0;
        cmd_arg    = '0;
        cmd_data   = '0;
        rsp_ready  = 1'b0;
        rv_select  = 6'd5;
        tb_attn    = 1'b0;
        tb_any     = 1'b0;

        #22;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_status", rsp_status, 0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_attention", attention, 0);
        check("rst_mst_valid", mst.valid, 0);
        check("rst_mst_mask", mst.mask, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) tick();
        check("idle_attention", attention, 0);
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_no_valid_pulse", vcount, 0);
        check("idle_scan_mask", mst.mask, 0);

        // Write-data command to the present target: 2 edges after accept = 3rd edge overall
        base = vcount;
        run_cmd(6'd5, OP_WRITE_DATA, 16'h0012, 32'hDEADBEEF, edges);
        check("wd_latency_edges", edges, 2);
        check("wd_rsp_data", rsp_data, 32'hDEADBEEF);
        check("wd_rsp_error", rsp_error, 0);
        check("wd_rsp_status", rsp_status, 4'b0001);
        check("wd_one_pulse", vcount - base, 1);
        ack();

        // Halt, then query: the query sees halted
        run_cmd(6'd5, OP_CONTROL, 16'h0001, 32'h0, edges);
        check("halt_edges", edges, 2);
        check("halt_rsp_status", rsp_status, 4'b0001);
        ack();
        run_cmd(6'd5, OP_WRITE_DATA, 16'h0000, 32'h0000_1111, edges);
        check("query_rsp_status_halted", rsp_status, 4'b0011);
        check("query_rsp_data", rsp_data, 32'h0000_1111);
        ack();

        // Attention raised by the target appears within 3 cycles
        tb_attn = 1'b1;
        edges = 0;
        while (!attention && edges < 3) begin
            tick();
            edges++;
        end
        check("attn_raised", attention, 1);
        tb_attn = 1'b0;
        repeat (3) tick();
        check("attn_dropped", attention, 0);

        // No target at select 9: ISSUE edge plus 15 WAIT cycles
        run_cmd(6'd9, OP_WRITE_DATA, 16'h0000, 32'h5555_AAAA, edges);
        check("to_edges", edges, 16);
        check("to_rsp_error", rsp_error, 2'b01);
        check("to_rsp_data", rsp_data, 0);
        check("to_rsp_status", rsp_status, 0);
        ack();

        // Target answers but reports a different select
        tb_any = 1'b1;
        run_cmd(6'd7, OP_WRITE_DATA, 16'h0000, 32'h0BAD_0007, edges);
        tb_any = 1'b0;
        check("mm_edges", edges, 2);
        check("mm_rsp_error", rsp_error, 2'b10);
        check("mm_rsp_data", rsp_data, 32'h0BAD_0007);
        ack();

        // Hold the response 10 cycles with a pending command
        run_cmd(6'd5, OP_WRITE_DATA, 16'h0000, 32'h1234_5678, edges);
        check("hold_first_edges", edges, 2);
        cmd_valid  = 1'b1;
        cmd_select = 6'd5;
        cmd_op     = OP_WRITE_DATA;
        cmd_arg    = 16'h0;
        cmd_data   = 32'hA5A5_A5A5;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_rsp_data", rsp_data, 32'h1234_5678);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("hold_release_cmd_ready", cmd_ready, 1);
        check("hold_release_rsp_valid", rsp_valid, 0);
        check("hold_keep_rsp_data", rsp_data, 32'h1234_5678);
        tick();
        cmd_valid = 1'b0;
        check("hold_accept_valid", mst.valid, 1);
        check("hold_accept_data", mst.data, 32'hA5A5_A5A5);
        edges = 0;
        while (!rsp_valid && edges < 40) begin
            tick();
            edges++;
        end
        check("hold_second_edges", edges, 2);
        check("hold_second_data", rsp_data, 32'hA5A5_A5A5);
        ack();

        // Reset during WAIT
        cmd_valid  = 1'b1;
        cmd_select = 6'd5;
        cmd_op     = OP_WRITE_DATA;
        cmd_data   = 32'h7777_0000;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("rw_in_wait", rsp_valid, 0);
        reset_n = 1'b0;
        #1;
        check("rw_rsp_valid", rsp_valid, 0);
        check("rw_cmd_ready", cmd_ready, 1);
        check("rw_mst_valid", mst.valid, 0);
        check("rw_mst_mask", mst.mask, 0);
        check("rw_rsp_data", rsp_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        run_cmd(6'd5, OP_WRITE_DATA, 16'h0000, 32'hCAFE_F00D, edges);
        check("post_rst_edges", edges, 2);
        check("post_rst_error", rsp_error, 0);
        check("post_rst_data", rsp_data, 32'hCAFE_F00D);
        check("post_rst_status", rsp_status, 4'b0001);
        ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
